hitlc_comb_seq: RTL

- Sequencer and collector for the layer-combination fit loop.
- On `start` it steps `sel_chi` through every combination index toward the hitmap/lcmap selection mux. It then captures the returned hitmap, lcmap and chi2 for each index after a fixed pipeline latency.
- It reports the passing combination with the lowest chi2.
- It sits between the track-candidate control logic and the combination mux/fitter datapath: it drives the mux select and consumes the mux's delayed output.

---
 rtl/gf_comb_pkg.sv | 24 ++
 rtl/sel_delay_line.sv | 43 ++++
 rtl/hitlc_comb_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gf_comb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf_comb_pkg
//  Description : Shared sizes and sequencer states for the layer-combination
//                fit loop (combination sweep, mux select, result collection).
//  Revision    : 1.0  initial release
// ============================================================================
package gf_comb_pkg;

    localparam int NCOMB = 6;
    localparam int SEL_W = 3;
    localparam int MAP_W = 5;
    localparam int CHI_W = 16;
    localparam int LAT   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sel_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sel_delay_line
//  Description : LAT-deep shift register carrying {valid, index} so that a
//                consumer of the mux output knows which index each result is.
//  Revision    : 1.0  initial release
// ============================================================================
module sel_delay_line #(
    parameter int LAT = 2,
    parameter int W   = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] r_valid;
    logic [W-1:0]   r_data [LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_data;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[LAT-1];
    assign out_data  = r_data[LAT-1];

endmodule
`default_nettype wire

// File: rtl/hitlc_comb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hitlc_comb_seq
//  Description : Steps sel_chi through all combinations, collects the delayed
//                fit results and keeps the passing one with the lowest chi2.
//  Revision    : 1.0  initial release
// ============================================================================
module hitlc_comb_seq #(
    parameter int NCOMB = gf_comb_pkg::NCOMB,
    parameter int LAT   = gf_comb_pkg::LAT,
    parameter int CHI_W = gf_comb_pkg::CHI_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic [gf_comb_pkg::SEL_W-1:0] sel_chi,
    input  logic [gf_comb_pkg::MAP_W-1:0] hitmap_in,
    input  logic [gf_comb_pkg::MAP_W-1:0] lcmap_in,
    input  logic [CHI_W-1:0]              chi2_in,
    input  logic                          chi2_ok,
    output logic                          done,
    output logic                          found,
    output logic [gf_comb_pkg::SEL_W-1:0] best_sel,
    output logic [gf_comb_pkg::MAP_W-1:0] best_hitmap,
    output logic [gf_comb_pkg::MAP_W-1:0] best_lcmap,
    output logic [CHI_W-1:0]              best_chi2
);

    import gf_comb_pkg::*;

    localparam logic [SEL_W-1:0] c_last = SEL_W'(NCOMB - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic               w_accept;
    logic               w_issue;
    logic               w_dly_valid;
    logic [SEL_W-1:0]   w_dly_idx;
    logic               w_take;

    logic               r_found;
    logic [SEL_W-1:0]   r_best_sel;
    logic [MAP_W-1:0]   r_best_hitmap;
    logic [MAP_W-1:0]   r_best_lcmap;
    logic [CHI_W-1:0]   r_best_chi2;

    assign w_issue = (r_state == ISSUE);

    sel_delay_line #(
        .LAT (LAT),
        .W   (SEL_W)
    ) u_sel_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (w_issue),
        .in_data   (r_idx),
        .out_valid (w_dly_valid),
        .out_data  (w_dly_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_idx == c_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            // The last issued index emerging from the delay line ends the drain.
            DRAIN: begin
                if (w_dly_valid && (w_dly_idx == c_last)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_accept    = start;
                w_state_nxt = start ? ISSUE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Strict less-than: on a tie the earlier (lower) index is kept.
    assign w_take = w_dly_valid && chi2_ok && (!r_found || (chi2_in < r_best_chi2));

    always_ff @(posedge clock) begin
        if (reset || w_accept) begin
            r_found       <= 1'b0;
            r_best_sel    <= '0;
            r_best_hitmap <= '0;
            r_best_lcmap  <= '0;
            r_best_chi2   <= '1;
        end else if (w_take) begin
            r_found       <= 1'b1;
            r_best_sel    <= w_dly_idx;
            r_best_hitmap <= hitmap_in;
            r_best_lcmap  <= lcmap_in;
            r_best_chi2   <= chi2_in;
        end
    end

    assign busy        = (r_state == ISSUE) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign sel_chi     = r_idx;
    assign found       = r_found;
    assign best_sel    = r_best_sel;
    assign best_hitmap = r_best_hitmap;
    assign best_lcmap  = r_best_lcmap;
    assign best_chi2   = r_best_chi2;

endmodule
`default_nettype wire
